// File: rtl/hamming_decoder_if.sv
// Bus between the SECDED decoder and the core/data-memory side: the start/done
// handoff, the byte-wide data-memory port and the per-run error counters.
interface hamming_decoder_if #(
  parameter int AW = 8
);
  logic          start;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [3:0]    err1_cnt;
  logic [3:0]    err2_cnt;

  // Decoder side: drives the memory port and reports status.
  modport master (
    input  start,
    input  mem_rd_data,
    output done,
    output mem_addr,
    output mem_wr_en,
    output mem_wr_data,
    output err1_cnt,
    output err2_cnt
  );

  // Core/memory side: issues start and returns read data.
  modport slave (
    output start,
    output mem_rd_data,
    input  done,
    input  mem_addr,
    input  mem_wr_en,
    input  mem_wr_data,
    input  err1_cnt,
    input  err2_cnt
  );
endinterface

// File: rtl/hamming_decoder.sv
// SECDED (16,11) decoder. Reads NUM_WORDS little-endian codewords from SRC_BASE,
// corrects single-bit errors, flags double-bit errors and writes each 11-bit
// message plus two status flags back to DST_BASE. Five cycles per word.
module hamming_decoder #(
  parameter int AW        = 8,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int NUM_WORDS = 15
) (
  input  logic              clk,
  input  logic              reset,
  hamming_decoder_if.master bus
);

  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    FIX,
    WR_LO,
    WR_HI,
    FIN
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   out_q, out_d;
  logic [3:0]    err1_q, err1_d;
  logic [3:0]    err2_q, err2_d;

  logic [15:0]   cw;
  logic [3:0]    syn;
  logic          par;
  logic          fix_en;
  logic [1:0]    flags;
  logic [10:0]   msg;
  logic [3:0]    pos;

  logic [AW-1:0] word_off;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;

  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic          done;

  // Syndrome, overall parity, classification and corrected message extraction.
  always_comb begin
    cw     = {hi_q, lo_q};
    syn    = '0;
    pos    = '0;
    msg    = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      if (cw[k]) syn = syn ^ k[3:0];
    end
    par    = ^cw;
    fix_en = (syn != 4'd0) && par;
    if (syn != 4'd0) flags = par ? 2'b01 : 2'b10;
    else             flags = par ? 2'b01 : 2'b00;
    // Data bits live at positions 3, 5..7, 9..15; flip the one the syndrome names.
    for (int unsigned j = 0; j < 11; j++) begin
      if (j == 0)      pos = 4'd3;
      else if (j <= 3) pos = 4'(j + 4);
      else             pos = 4'(j + 5);
      msg[j] = cw[pos] ^ (fix_en && (syn == pos));
    end
  end

  // Byte addresses of the current word in the source and destination regions.
  always_comb begin
    word_off = AW'({idx_q, 1'b0});
    src_addr = AW'(SRC_BASE) + word_off;
    dst_addr = AW'(DST_BASE) + word_off;
  end

  // Next-state and memory-port outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    out_d       = out_q;
    err1_d      = err1_q;
    err2_d      = err2_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RD_LO;
          idx_d   = '0;
          err1_d  = '0;
          err2_d  = '0;
        end
      end
      RD_LO: begin
        mem_addr = src_addr;
        lo_d     = bus.mem_rd_data;
        state_d  = RD_HI;
      end
      RD_HI: begin
        mem_addr = src_addr + AW'(1);
        hi_d     = bus.mem_rd_data;
        state_d  = FIX;
      end
      FIX: begin
        out_d = {flags, 3'b000, msg};
        if (flags == 2'b01 && err1_q != 4'hF) err1_d = err1_q + 4'd1;
        if (flags == 2'b10 && err2_q != 4'hF) err2_d = err2_q + 4'd1;
        state_d = WR_LO;
      end
      WR_LO: begin
        mem_addr    = dst_addr;
        mem_wr_en   = 1'b1;
        mem_wr_data = out_q[7:0];
        state_d     = WR_HI;
      end
      WR_HI: begin
        mem_addr    = dst_addr + AW'(1);
        mem_wr_en   = 1'b1;
        mem_wr_data = out_q[15:8];
        if (idx_q == IW'(NUM_WORDS - 1)) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = RD_LO;
        end
      end
      FIN: begin
        done = 1'b1;
        if (bus.start) begin
          state_d = RD_LO;
          idx_d   = '0;
          err1_d  = '0;
          err2_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      out_q   <= '0;
      err1_q  <= '0;
      err2_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      out_q   <= out_d;
      err1_q  <= err1_d;
      err2_q  <= err2_d;
    end
  end

  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wr_en   = mem_wr_en;
  assign bus.mem_wr_data = mem_wr_data;
  assign bus.done        = done;
  assign bus.err1_cnt    = err1_q;
  assign bus.err2_cnt    = err2_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Scoreboard bench for hamming_decoder: stimulus loads codewords and queues the
// expected memory writes; a monitor pops and checks every write strobe.
module tb_hamming_decoder;

  localparam int AW        = 8;
  localparam int SRC_BASE  = 30;
  localparam int DST_BASE  = 0;
  localparam int NUM_WORDS = 15;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Stimulus tables for the current run.
  logic [15:0] cw_tab  [NUM_WORDS];
  logic [10:0] exp_tab [NUM_WORDS];
  logic [1:0]  fl_tab  [NUM_WORDS];

  // Reference messages; 0x5A3 encodes to 0xB42D in this bit layout.
  logic [10:0] msgs [NUM_WORDS] = '{11'h5A3, 11'h000, 11'h7FF, 11'h001, 11'h400,
                                    11'h2AA, 11'h555, 11'h123, 11'h3C3, 11'h0F0,
                                    11'h70F, 11'h246, 11'h1B9, 11'h6DB, 11'h038};

  hamming_decoder_if #(.AW(AW)) bus ();

  hamming_decoder #(
    .AW(AW),
    .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE),
    .NUM_WORDS(NUM_WORDS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, clocked write; ld_* preloads while idle.
  assign bus.mem_rd_data = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
    else if (ld_en)    mem[ld_addr] <= ld_data;
  end

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.mem_wr_en) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%02h, required no write", bus.mem_addr, bus.mem_wr_data);
      end else begin
        mon_e = sb.pop_front();
        if (bus.mem_addr !== mon_e.addr || (bus.mem_wr_data & mon_e.mask) !== (mon_e.data & mon_e.mask)) begin
          n_fail++;
          $display("FAIL write: addr=%0d data=%02h, required addr=%0d data=%02h mask=%02h",
                   bus.mem_addr, bus.mem_wr_data, mon_e.addr, mon_e.data, mon_e.mask);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] c;
    c       = '0;
    c[3]    = m[0];
    c[7:5]  = m[3:1];
    c[15:9] = m[10:4];
    c[1]    = c[3] ^ c[5] ^ c[7] ^ c[9]  ^ c[11] ^ c[13] ^ c[15];
    c[2]    = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4]    = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8]    = ^c[15:9];
    c[0]    = ^c[15:1];
    return c;
  endfunction

  task automatic set_clean();
    for (int i = 0; i < NUM_WORDS; i++) begin
      cw_tab[i]  = encode(msgs[i]);
      exp_tab[i] = msgs[i];
      fl_tab[i]  = 2'b00;
    end
  endtask

  // Load codewords into memory and queue the expected write stream.
  task automatic prepare();
    logic [7:0] hi_exp;
    for (int i = 0; i < NUM_WORDS; i++) begin
      @(negedge clk); ld_en = 1'b1; ld_addr = 8'(SRC_BASE + 2 * i);     ld_data = cw_tab[i][7:0];
      @(negedge clk); ld_en = 1'b1; ld_addr = 8'(SRC_BASE + 2 * i + 1); ld_data = cw_tab[i][15:8];
    end
    @(negedge clk); ld_en = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      hi_exp = {fl_tab[i], 3'b000, exp_tab[i][10:8]};
      sb.push_back('{addr: 8'(DST_BASE + 2 * i), data: exp_tab[i][7:0],
                     mask: (fl_tab[i] == 2'b10) ? 8'h00 : 8'hFF});
      sb.push_back('{addr: 8'(DST_BASE + 2 * i + 1), data: hi_exp,
                     mask: (fl_tab[i] == 2'b10) ? 8'hC0 : 8'hFF});
    end
  endtask

  // Pulse start and count rising edges (including the sampling edge) until done.
  task automatic run(input string name, input int busy_at, input logic [3:0] e1, input logic [3:0] e2);
    int edges;
    edges = 0;
    @(negedge clk); bus.start = 1'b1;
    do begin
      @(posedge clk); #1;
      edges++;
      bus.start = (busy_at != 0) && (edges == busy_at);
      if (edges == 1) begin
        check({name, "_done_drop"}, 32'(bus.done), 32'd0);
        check({name, "_cnt_clear"}, 32'({bus.err1_cnt, bus.err2_cnt}), 32'd0);
      end
    end while (!bus.done && edges < 200);
    bus.start = 1'b0;
    check({name, "_cycles"}, 32'(edges), 32'd76);
    check({name, "_err1"}, 32'(bus.err1_cnt), 32'(e1));
    check({name, "_err2"}, 32'(bus.err2_cnt), 32'(e2));
    check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_hold"}, 32'(bus.done), 32'd1);
    check({name, "_err1_hold"}, 32'(bus.err1_cnt), 32'(e1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    reset     = 1'b1;
    bus.start = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("rst_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    check("rst_err1", 32'(bus.err1_cnt), 32'd0);
    check("rst_err2", 32'(bus.err2_cnt), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Clean words, with a start pulse mid-run that must be ignored.
    set_clean();
    prepare();
    run("clean", 20, 4'd0, 4'd0);

    // Single flips at bit positions 0..14 (bit 0 is the p0-only case), restart from FIN.
    for (int i = 0; i < NUM_WORDS; i++) begin
      cw_tab[i]  = encode(msgs[i]) ^ (16'd1 << i);
      exp_tab[i] = msgs[i];
      fl_tab[i]  = 2'b01;
    end
    prepare();
    run("single", 0, 4'd15, 4'd0);

    // Bit 15 flip; counters must restart from zero.
    set_clean();
    cw_tab[0] = encode(msgs[0]) ^ 16'h8000;
    fl_tab[0] = 2'b01;
    prepare();
    run("bit15", 0, 4'd1, 4'd0);

    // Double error (bits 3 and 9 of 0xB42D) and p0-only error (0xB42C).
    set_clean();
    cw_tab[0]  = encode(msgs[0]) ^ 16'h0208;
    fl_tab[0]  = 2'b10;
    cw_tab[1]  = encode(msgs[0]) ^ 16'h0001;
    exp_tab[1] = msgs[0];
    fl_tab[1]  = 2'b01;
    prepare();
    run("double_p0", 0, 4'd1, 4'd1);

    // Reset during word 7 WR_LO.
    prepare();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    waited = 0;
    while (!(bus.mem_wr_en && bus.mem_addr == 8'(DST_BASE + 14)) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("midrun_reach_word7", 32'(waited < 100), 32'd1);
    check("midrun_counts", 32'({bus.err1_cnt, bus.err2_cnt}), 32'h11);
    #2 reset = 1'b1;
    #1;
    check("midrun_rst_done", 32'(bus.done), 32'd0);
    check("midrun_rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check("midrun_rst_addr", 32'(bus.mem_addr), 32'd0);
    check("midrun_rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
    check("midrun_rst_err1", 32'(bus.err1_cnt), 32'd0);
    check("midrun_rst_err2", 32'(bus.err2_cnt), 32'd0);
    sb.delete();
    @(negedge clk); reset = 1'b0;
    set_clean();
    prepare();
    run("after_reset", 0, 4'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
